// File: rtl/mm2s_cmd_scheduler_if.sv
// DataMover command and status streams between the MM2S scheduler and the DataMover.
interface mm2s_cmd_scheduler_if;
    logic [71:0] m_axis_cmd_tdata;
    logic        m_axis_cmd_tvalid;
    logic        m_axis_cmd_tready;
    logic [7:0]  s_axis_sts_tdata;
    logic        s_axis_sts_tvalid;
    logic        s_axis_sts_tready;

    modport master (
        output m_axis_cmd_tdata, m_axis_cmd_tvalid, s_axis_sts_tready,
        input  m_axis_cmd_tready, s_axis_sts_tdata, s_axis_sts_tvalid
    );

    modport slave (
        input  m_axis_cmd_tdata, m_axis_cmd_tvalid, s_axis_sts_tready,
        output m_axis_cmd_tready, s_axis_sts_tdata, s_axis_sts_tvalid
    );
endinterface

// File: rtl/mm2s_cmd_scheduler.sv
// Slices a capture region into fixed-size DataMover read commands, optionally looping,
// with the number of unanswered commands capped by the status stream.
module mm2s_cmd_scheduler #(
    parameter int PACKET_SIZE     = 4096,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 axis_st_clk,
    input  logic                 axis_st_rstb,
    mm2s_cmd_scheduler_if.master dm,
    input  logic                 read_start,
    input  logic                 read_stop,
    input  logic                 read_reset,
    input  logic                 loop_en,
    input  logic [31:0]          start_address,
    input  logic [31:0]          cap_size,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [31:0]          cmd_count,
    output logic [7:0]           run_cycles,
    output logic [7:0]           last_status
);
    localparam logic [31:0] PKT     = 32'(PACKET_SIZE);
    localparam logic [3:0]  MAX_OUT = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, CMD, DRAIN, ERR} state_t;

    state_t      state;
    logic [31:0] base;
    logic [31:0] size;
    logic [31:0] offset;
    logic [3:0]  outstanding;
    logic        stop_pending;
    logic [71:0] cmd_tdata;
    logic        cmd_tvalid;

    logic        hs;
    logic        sts_beat;
    logic        sts_bad;
    logic        sts_dec;
    logic        stop_now;
    logic        chunk_last;
    logic [31:0] next_off;
    logic [3:0]  out_next;

    function automatic logic [71:0] build_cmd(input logic [31:0] b, input logic [31:0] s,
                                              input logic [31:0] off, input logic [3:0] tag);
        logic [31:0] remaining;
        logic        last;
        logic [22:0] btt;
        remaining = s - off;
        last      = (remaining <= PKT);
        btt       = last ? remaining[22:0] : PKT[22:0];
        return {4'h0, tag, b + off, 1'b0, last, 6'h00, 1'b1, btt};
    endfunction

    always_comb begin
        hs         = cmd_tvalid & dm.m_axis_cmd_tready;
        sts_beat   = dm.s_axis_sts_tvalid;
        sts_bad    = sts_beat & ((dm.s_axis_sts_tdata[6:4] != 3'd0) | ~dm.s_axis_sts_tdata[7]);
        sts_dec    = sts_beat & ((outstanding != 4'd0) | hs);
        stop_now   = stop_pending | read_stop | sts_bad;
        // The command being handed off carries its own BTT and last-chunk flag.
        chunk_last = cmd_tdata[30];
        next_off   = chunk_last ? 32'd0 : offset + {9'd0, cmd_tdata[22:0]};
        out_next   = outstanding;
        if (hs && !sts_dec)
            out_next = outstanding + 4'd1;
        else if (!hs && sts_dec)
            out_next = outstanding - 4'd1;
    end

    always_ff @(posedge axis_st_clk or negedge axis_st_rstb) begin
        if (!axis_st_rstb) begin
            state        <= IDLE;
            base         <= '0;
            size         <= '0;
            offset       <= '0;
            outstanding  <= '0;
            stop_pending <= 1'b0;
            cmd_tdata    <= '0;
            cmd_tvalid   <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            cmd_count    <= '0;
            run_cycles   <= '0;
            last_status  <= '0;
        end else if (read_reset) begin
            state        <= IDLE;
            base         <= '0;
            size         <= '0;
            offset       <= '0;
            outstanding  <= '0;
            stop_pending <= 1'b0;
            cmd_tdata    <= '0;
            cmd_tvalid   <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            cmd_count    <= '0;
            run_cycles   <= '0;
            last_status  <= '0;
        end else begin
            done        <= 1'b0;
            outstanding <= out_next;
            if (sts_beat) begin
                last_status <= dm.s_axis_sts_tdata;
                if (sts_bad) begin
                    err          <= 1'b1;
                    stop_pending <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (read_start && cap_size != 32'd0) begin
                        base         <= start_address;
                        size         <= cap_size;
                        offset       <= '0;
                        cmd_count    <= '0;
                        run_cycles   <= '0;
                        err          <= 1'b0;
                        stop_pending <= 1'b0;
                        cmd_tdata    <= build_cmd(start_address, cap_size, 32'd0, 4'd0);
                        cmd_tvalid   <= 1'b1;
                        state        <= CMD;
                    end
                end
                CMD: begin
                    if (read_stop)
                        stop_pending <= 1'b1;
                    if (hs) begin
                        cmd_count <= cmd_count + 32'd1;
                        offset    <= next_off;
                        if (chunk_last)
                            run_cycles <= run_cycles + 8'd1;
                        if (stop_now || (chunk_last && !loop_en)) begin
                            cmd_tvalid <= 1'b0;
                            state      <= DRAIN;
                        end else if (out_next < MAX_OUT) begin
                            cmd_tdata <= build_cmd(base, size, next_off, cmd_count[3:0] + 4'd1);
                        end else begin
                            cmd_tvalid <= 1'b0;
                        end
                    end else if (!cmd_tvalid) begin
                        // A raised tvalid is never withdrawn; only an idle slot may stop or refill.
                        if (stop_now) begin
                            state <= DRAIN;
                        end else if (out_next < MAX_OUT) begin
                            cmd_tdata  <= build_cmd(base, size, offset, cmd_count[3:0]);
                            cmd_tvalid <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (outstanding == 4'd0) begin
                        if (err) begin
                            state <= ERR;
                        end else begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                ERR: state <= ERR;
                default: state <= IDLE;
            endcase
        end
    end

    assign dm.m_axis_cmd_tdata  = cmd_tdata;
    assign dm.m_axis_cmd_tvalid = cmd_tvalid;
    assign dm.s_axis_sts_tready = 1'b1;
    assign busy                 = (state != IDLE);
endmodule

// File: tb/tb_mm2s_cmd_scheduler.sv
// Scoreboard bench for mm2s_cmd_scheduler: expected commands are queued by the stimulus
// and checked by a monitor on every command handshake.
module tb_mm2s_cmd_scheduler;
    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        read_start = 1'b0;
    logic        read_stop = 1'b0;
    logic        read_reset = 1'b0;
    logic        loop_en = 1'b0;
    logic [31:0] start_address = '0;
    logic [31:0] cap_size = '0;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] cmd_count;
    logic [7:0]  run_cycles;
    logic [7:0]  last_status;

    mm2s_cmd_scheduler_if dm();

    mm2s_cmd_scheduler #(.PACKET_SIZE(4096), .MAX_OUTSTANDING(4)) dut (
        .axis_st_clk   (clk),
        .axis_st_rstb  (rstb),
        .dm            (dm),
        .read_start    (read_start),
        .read_stop     (read_stop),
        .read_reset    (read_reset),
        .loop_en       (loop_en),
        .start_address (start_address),
        .cap_size      (cap_size),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .cmd_count     (cmd_count),
        .run_cycles    (run_cycles),
        .last_status   (last_status)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          credits = 0;
    logic        auto_sts = 1'b0;
    logic [4:0]  bad_tag = 5'h10;
    logic [71:0] exp_q[$];
    logic [3:0]  pending[$];

    function automatic void chk(input string name, input logic [71:0] act, input logic [71:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endfunction

    function automatic logic [71:0] exp_cmd(input logic [31:0] addr, input logic [22:0] btt,
                                            input logic eof, input logic [3:0] tag);
        return {4'h0, tag, addr, 1'b0, eof, 6'h00, 1'b1, btt};
    endfunction

    // Monitor: command handshakes and done pulses, sampled on the falling edge.
    always @(negedge clk) begin
        if (rstb && dm.m_axis_cmd_tvalid && dm.m_axis_cmd_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cmd: got 0x%0h, required no command", dm.m_axis_cmd_tdata);
            end else begin
                chk("cmd_tdata", dm.m_axis_cmd_tdata, exp_q.pop_front());
            end
            pending.push_back(dm.m_axis_cmd_tdata[67:64]);
        end
        if (rstb && done) begin
            done_cnt++;
            chk("busy_at_done", 72'(busy), 72'(0));
        end
    end

    // Status responder: one beat per accepted command, freely or against granted credits.
    initial begin
        dm.s_axis_sts_tvalid = 1'b0;
        dm.s_axis_sts_tdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            if ((auto_sts || credits > 0) && pending.size() > 0) begin
                logic [3:0] tag;
                tag = pending.pop_front();
                dm.s_axis_sts_tdata  = ({1'b0, tag} == bad_tag) ? 8'h41 : {4'h8, tag};
                dm.s_axis_sts_tvalid = 1'b1;
                if (!auto_sts)
                    credits--;
            end else begin
                dm.s_axis_sts_tvalid = 1'b0;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [31:0] a, input logic [31:0] s, input logic lp);
        start_address = a;
        cap_size      = s;
        loop_en       = lp;
        read_start    = 1'b1;
        cycles(1);
        read_start    = 1'b0;
    endtask

    task automatic pulse_reset();
        read_reset = 1'b1;
        cycles(1);
        read_reset = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int start_cnt;
        start_cnt = done_cnt;
        for (int i = 0; i < max_cycles; i++) begin
            cycles(1);
            if (done_cnt > start_cnt)
                return;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done pulse in %0d cycles, required one", max_cycles);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, 72'(dm.m_axis_cmd_tvalid), 72'(0));
        chk({tag, "_tdata"}, dm.m_axis_cmd_tdata, 72'(0));
        chk({tag, "_sts_tready"}, 72'(dm.s_axis_sts_tready), 72'(1));
        chk({tag, "_busy"}, 72'(busy), 72'(0));
        chk({tag, "_done"}, 72'(done), 72'(0));
        chk({tag, "_err"}, 72'(err), 72'(0));
        chk({tag, "_cmd_count"}, 72'(cmd_count), 72'(0));
        chk({tag, "_run_cycles"}, 72'(run_cycles), 72'(0));
        chk({tag, "_last_status"}, 72'(last_status), 72'(0));
    endtask

    initial begin
        dm.m_axis_cmd_tready = 1'b1;
        #23;
        check_reset_outputs("rst");
        rstb = 1'b1;
        cycles(2);

        // Single pass over 10000 bytes.
        exp_q.push_back(exp_cmd(32'h1000_0000, 23'd4096, 1'b0, 4'd0));
        exp_q.push_back(exp_cmd(32'h1000_1000, 23'd4096, 1'b0, 4'd1));
        exp_q.push_back(exp_cmd(32'h1000_2000, 23'd1808, 1'b1, 4'd2));
        auto_sts = 1'b1;
        start_run(32'h1000_0000, 32'd10000, 1'b0);
        chk("sp_tvalid_latency", 72'(dm.m_axis_cmd_tvalid), 72'(1));
        chk("sp_busy", 72'(busy), 72'(1));
        wait_done(100);
        chk("sp_run_cycles", 72'(run_cycles), 72'(1));
        chk("sp_cmd_count", 72'(cmd_count), 72'(3));
        chk("sp_busy_after", 72'(busy), 72'(0));
        chk("sp_last_status", 72'(last_status), 72'(8'h82));
        chk("sp_all_cmds", 72'(exp_q.size()), 72'(0));
        auto_sts = 1'b0;
        cycles(2);

        // Flow control: no status until a single credit is granted.
        for (int i = 0; i < 5; i++)
            exp_q.push_back(exp_cmd(32'h2000_0000 + 32'(i) * 32'h1000, 23'd4096, 1'b0, 4'(i)));
        start_run(32'h2000_0000, 32'd65536, 1'b0);
        cycles(20);
        chk("fc_count_cap", 72'(cmd_count), 72'(4));
        chk("fc_tvalid_low", 72'(dm.m_axis_cmd_tvalid), 72'(0));
        credits = 1;
        cycles(20);
        chk("fc_one_more", 72'(cmd_count), 72'(5));
        chk("fc_tvalid_low2", 72'(dm.m_axis_cmd_tvalid), 72'(0));
        chk("fc_last_status", 72'(last_status), 72'(8'h80));
        pulse_reset();
        pending.delete();
        chk("fc_rst_busy", 72'(busy), 72'(0));
        chk("fc_rst_count", 72'(cmd_count), 72'(0));
        chk("fc_all_cmds", 72'(exp_q.size()), 72'(0));
        cycles(2);

        // Loop over 8192 bytes, stop after the fifth command.
        exp_q.push_back(exp_cmd(32'h3000_0000, 23'd4096, 1'b0, 4'd0));
        exp_q.push_back(exp_cmd(32'h3000_1000, 23'd4096, 1'b1, 4'd1));
        exp_q.push_back(exp_cmd(32'h3000_0000, 23'd4096, 1'b0, 4'd2));
        exp_q.push_back(exp_cmd(32'h3000_1000, 23'd4096, 1'b1, 4'd3));
        exp_q.push_back(exp_cmd(32'h3000_0000, 23'd4096, 1'b0, 4'd4));
        start_run(32'h3000_0000, 32'd8192, 1'b1);
        cycles(15);
        credits = 1;
        cycles(10);
        chk("lp_count5", 72'(cmd_count), 72'(5));
        read_stop = 1'b1;
        cycles(1);
        read_stop = 1'b0;
        cycles(5);
        chk("lp_busy_draining", 72'(busy), 72'(1));
        chk("lp_tvalid_low", 72'(dm.m_axis_cmd_tvalid), 72'(0));
        auto_sts = 1'b1;
        wait_done(50);
        chk("lp_run_cycles", 72'(run_cycles), 72'(2));
        chk("lp_cmd_count", 72'(cmd_count), 72'(5));
        chk("lp_last_status", 72'(last_status), 72'(8'h84));
        chk("lp_all_cmds", 72'(exp_q.size()), 72'(0));
        auto_sts = 1'b0;
        loop_en  = 1'b0;
        cycles(2);

        // Error status on tag 1 stops issue and parks in the error state.
        for (int i = 0; i < 5; i++)
            exp_q.push_back(exp_cmd(32'h4000_0000 + 32'(i) * 32'h1000, 23'd4096, 1'b0, 4'(i)));
        start_run(32'h4000_0000, 32'd65536, 1'b0);
        cycles(15);
        bad_tag  = 5'd1;
        auto_sts = 1'b1;
        cycles(30);
        chk("er_err", 72'(err), 72'(1));
        chk("er_busy_in_err", 72'(busy), 72'(1));
        chk("er_cmd_count", 72'(cmd_count), 72'(5));
        chk("er_tvalid_low", 72'(dm.m_axis_cmd_tvalid), 72'(0));
        chk("er_no_done", 72'(done_cnt), 72'(2));
        chk("er_last_status", 72'(last_status), 72'(8'h84));
        start_run(32'h4000_0000, 32'd4096, 1'b0);
        cycles(3);
        chk("er_start_ignored", 72'(cmd_count), 72'(5));
        chk("er_still_err", 72'(err), 72'(1));
        chk("er_tvalid_ignored", 72'(dm.m_axis_cmd_tvalid), 72'(0));
        pulse_reset();
        chk("er_rst_err", 72'(err), 72'(0));
        chk("er_rst_busy", 72'(busy), 72'(0));
        chk("er_all_cmds", 72'(exp_q.size()), 72'(0));
        auto_sts = 1'b0;
        bad_tag  = 5'h10;
        cycles(2);

        // read_reset while a command is stalled.
        dm.m_axis_cmd_tready = 1'b0;
        start_run(32'h5000_0000, 32'd4096, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("mc_tdata_stable", dm.m_axis_cmd_tdata, 72'h00_5000_0000_4080_1000);
            chk("mc_tvalid_held", 72'(dm.m_axis_cmd_tvalid), 72'(1));
            cycles(1);
        end
        pulse_reset();
        chk("mc_rst_tvalid", 72'(dm.m_axis_cmd_tvalid), 72'(0));
        chk("mc_rst_count", 72'(cmd_count), 72'(0));
        dm.m_axis_cmd_tready = 1'b1;
        cycles(2);

        // Zero-size start is ignored.
        start_run(32'h5000_0000, 32'd0, 1'b0);
        cycles(5);
        chk("zs_busy", 72'(busy), 72'(0));
        chk("zs_tvalid", 72'(dm.m_axis_cmd_tvalid), 72'(0));

        // Asynchronous reset between clock edges while a command is pending.
        dm.m_axis_cmd_tready = 1'b0;
        start_run(32'h6000_0000, 32'd100, 1'b0);
        chk("ar_tvalid_before", 72'(dm.m_axis_cmd_tvalid), 72'(1));
        #2 rstb = 1'b0;
        #1 check_reset_outputs("arst");
        cycles(2);
        rstb = 1'b1;
        dm.m_axis_cmd_tready = 1'b1;
        cycles(3);
        chk("ar_idle_after", 72'(busy), 72'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
